// File: rtl/cpu_host_bridge_if.sv
// Host-side command/response handshake bundle for the CPU host bridge.
// The master drives commands and accepts responses; the slave is the bridge.
interface cpu_host_bridge_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_operand;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_sign;
  logic        rsp_overflow;

  modport master (
    output cmd_valid, cmd_opcode, cmd_operand, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_sign, rsp_overflow
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_operand, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_sign, rsp_overflow
  );
endinterface

// File: rtl/cpu_host_bridge.sv
// Drives a host command to the CPU core as a held instruction word, then
// reassembles the core's byte-serial result (high byte first) plus flags.
module cpu_host_bridge #(
  parameter int unsigned HOLD_CYCLES = 3,
  parameter logic [3:0]  IDLE_OPCODE = 4'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_host_bridge_if.slave   host,
  output logic [19:0]        cpu_data_in,
  input  logic [7:0]         cpu_data_out,
  input  logic               cpu_flag_carry,
  input  logic               cpu_flag_sign,
  input  logic               cpu_flag_overflow,
  output logic               busy,
  output logic [7:0]         txn_count
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WORD_W = 20;
  localparam logic [WORD_W-1:0] IDLE_WORD = {IDLE_OPCODE, 16'h0000};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    CAP_HI = 3'd2,
    CAP_LO = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               rsp_valid_q;
  logic [15:0]        rsp_result_q;
  logic               rsp_carry_q;
  logic               rsp_sign_q;
  logic               rsp_overflow_q;

  assign host.cmd_ready    = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign host.rsp_valid    = rsp_valid_q;
  assign host.rsp_result   = rsp_result_q;
  assign host.rsp_carry    = rsp_carry_q;
  assign host.rsp_sign     = rsp_sign_q;
  assign host.rsp_overflow = rsp_overflow_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host.cmd_valid) state_d = DRIVE;
      DRIVE:   if (cnt_q == '0) state_d = CAP_HI;
      CAP_HI:  state_d = CAP_LO;
      CAP_LO:  state_d = RESP;
      RESP:    if (host.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Instruction word, hold counter, result capture and handshake bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_data_in    <= IDLE_WORD;
      cnt_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_sign_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      txn_count      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host.cmd_valid) begin
            cpu_data_in <= {host.cmd_opcode, host.cmd_operand};
            cnt_q       <= CNT_W'(HOLD_CYCLES - 1);
          end
        end
        DRIVE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        CAP_HI: begin
          rsp_result_q[15:8] <= cpu_data_out;
        end
        CAP_LO: begin
          rsp_result_q[7:0] <= cpu_data_out;
          rsp_carry_q       <= cpu_flag_carry;
          rsp_sign_q        <= cpu_flag_sign;
          rsp_overflow_q    <= cpu_flag_overflow;
          rsp_valid_q       <= 1'b1;
          cpu_data_in       <= IDLE_WORD;
        end
        RESP: begin
          if (host.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            txn_count   <= txn_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_host_bridge.sv
// Scoreboard bench for cpu_host_bridge: HOLD_CYCLES=3 instance for the main
// scenarios, plus a HOLD_CYCLES=1 instance for the short-latency variant.
module tb_cpu_host_bridge;
  localparam int unsigned H0 = 3;
  localparam int unsigned H1 = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cpu_data_out;
  logic        cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow;
  logic [19:0] cpu_data_in0, cpu_data_in1;
  logic        busy0, busy1;
  logic [7:0]  txn0, txn1;

  always #5 clk = ~clk;

  cpu_host_bridge_if hb0 ();
  cpu_host_bridge_if hb1 ();

  cpu_host_bridge #(.HOLD_CYCLES(H0), .IDLE_OPCODE(4'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .host(hb0),
    .cpu_data_in(cpu_data_in0), .cpu_data_out(cpu_data_out),
    .cpu_flag_carry(cpu_flag_carry), .cpu_flag_sign(cpu_flag_sign),
    .cpu_flag_overflow(cpu_flag_overflow), .busy(busy0), .txn_count(txn0)
  );

  cpu_host_bridge #(.HOLD_CYCLES(H1), .IDLE_OPCODE(4'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .host(hb1),
    .cpu_data_in(cpu_data_in1), .cpu_data_out(cpu_data_out),
    .cpu_flag_carry(cpu_flag_carry), .cpu_flag_sign(cpu_flag_sign),
    .cpu_flag_overflow(cpu_flag_overflow), .busy(busy1), .txn_count(txn1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_acc = -1;
  logic [18:0] sb[$];
  logic [18:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && hb0.rsp_valid === 1'b1 && hb0.rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got result %0h expected no response", hb0.rsp_result);
      end else begin
        mon_exp = sb.pop_front();
        check("rsp_result", 32'(hb0.rsp_result), 32'(mon_exp[18:3]));
        check("rsp_flags", 32'({hb0.rsp_carry, hb0.rsp_sign, hb0.rsp_overflow}),
              32'(mon_exp[2:0]));
      end
    end
  end

  task automatic wait_ready0();
    int guard = 0;
    @(negedge clk);
    while (hb0.cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("cmd_ready_timeout", 32'(hb0.cmd_ready), 32'd1);
  endtask

  // Issue one command on dut0 and play the core side; returns at the negedge
  // after the edge on which rsp_valid should have risen.
  task automatic do_cmd(input logic [3:0] op, input logic [15:0] opd,
                        input logic [7:0] hi, input logic [7:0] lo,
                        input logic [2:0] f, input bit chk_sp);
    logic [19:0] word;
    word = {op, opd};
    wait_ready0();
    hb0.cmd_opcode  = op;
    hb0.cmd_operand = opd;
    hb0.cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    hb0.cmd_valid   = 1'b0;
    hb0.cmd_opcode  = ~op;
    hb0.cmd_operand = ~opd;
    sb.push_back({hi, lo, f});
    if (chk_sp && last_acc >= 0) check("cmd_spacing", 32'(cyc - last_acc), 32'(H0 + 4));
    last_acc = cyc;
    for (int k = 0; k <= int'(H0) + 1; k++) begin
      if (k < int'(H0)) begin
        cpu_data_out = hi ^ 8'hFF ^ 8'(k);
        {cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow} = (k % 2 == 0) ? ~f : f;
      end else if (k == int'(H0)) begin
        cpu_data_out = hi;
        {cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow} = ~f;
      end else begin
        cpu_data_out = lo;
        {cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow} = f;
      end
      @(negedge clk);
      check("cpu_data_in_hold", 32'(cpu_data_in0), 32'(word));
      check("rsp_valid_early", 32'(hb0.rsp_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    cpu_data_out = ~lo;
    {cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow} = ~f;
    @(negedge clk);
    check("rsp_valid_latency", 32'(hb0.rsp_valid), 32'd1);
    check("cpu_data_in_idle", 32'(cpu_data_in0), 32'h00000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   first_valid;
    bit   saw_valid;
    rst_n = 1'b0;
    hb0.cmd_valid = 1'b0; hb0.cmd_opcode = '0; hb0.cmd_operand = '0; hb0.rsp_ready = 1'b1;
    hb1.cmd_valid = 1'b0; hb1.cmd_opcode = '0; hb1.cmd_operand = '0; hb1.rsp_ready = 1'b0;
    cpu_data_out = 8'h00;
    {cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow} = 3'b000;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(hb0.cmd_ready), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_rsp_valid", 32'(hb0.rsp_valid), 32'd0);
    check("rst_cpu_data_in", 32'(cpu_data_in0), 32'h00000);
    check("rst_txn_count", 32'(txn0), 32'd0);
    check("rst_rsp_result", 32'(hb0.rsp_result), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic transaction
    do_cmd(4'h1, 16'h1234, 8'hAB, 8'hCD, 3'b100, 1'b0);
    @(negedge clk);
    check("basic_txn_count", 32'(txn0), 32'd1);
    check("basic_idle", 32'(hb0.cmd_ready), 32'd1);

    // Backpressure with an ignored command during the stall
    hb0.rsp_ready = 1'b0;
    do_cmd(4'h1, 16'h1234, 8'hAB, 8'hCD, 3'b100, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      cpu_data_out = 8'(i * 37);
      {cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow} = 3'(i);
      hb0.cmd_valid = 1'b1; hb0.cmd_opcode = 4'h7; hb0.cmd_operand = 16'h5555;
      @(negedge clk);
      check("stall_result", 32'(hb0.rsp_result), 32'h0000ABCD);
      check("stall_carry", 32'(hb0.rsp_carry), 32'd1);
      check("stall_cmd_ready", 32'(hb0.cmd_ready), 32'd0);
      check("stall_rsp_valid", 32'(hb0.rsp_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    hb0.cmd_valid = 1'b0;
    hb0.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_idle", 32'(hb0.cmd_ready), 32'd1);
    check("release_rsp_valid", 32'(hb0.rsp_valid), 32'd0);
    check("release_txn_count", 32'(txn0), 32'd2);
    check("ignored_cmd_word", 32'(cpu_data_in0), 32'h00000);

    // Negative operand, sign toggling before CAP_LO
    do_cmd(4'h2, 16'hFFFE, 8'h80, 8'h01, 3'b010, 1'b0);
    @(negedge clk);
    check("neg_txn_count", 32'(txn0), 32'd3);

    // Reset in CAP_HI abandons the transaction
    wait_ready0();
    hb0.cmd_opcode = 4'h3; hb0.cmd_operand = 16'h0055; hb0.cmd_valid = 1'b1;
    @(posedge clk);
    #1 hb0.cmd_valid = 1'b0;
    repeat (H0) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", 32'(hb0.cmd_ready), 32'd1);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_cpu_data_in", 32'(cpu_data_in0), 32'h00000);
    check("midrst_txn_count", 32'(txn0), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (hb0.rsp_valid === 1'b1) saw_valid = 1'b1;
    end
    check("midrst_no_rsp", 32'(saw_valid), 32'd0);
    check("midrst_txn_after", 32'(txn0), 32'd0);
    last_acc = -1;

    // 256 back-to-back commands: wrap and spacing
    for (int i = 0; i < 256; i++) begin
      do_cmd(4'(i), 16'(i * 257), 8'(i), 8'(~i), 3'(i), 1'b1);
    end
    @(negedge clk);
    check("wrap_txn_count", 32'(txn0), 32'd0);
    check("wrap_idle", 32'(hb0.cmd_ready), 32'd1);

    // HOLD_CYCLES=1 instance: latency 3
    @(posedge clk);
    #1;
    hb1.cmd_opcode = 4'h5; hb1.cmd_operand = 16'h8001; hb1.cmd_valid = 1'b1;
    @(posedge clk);
    #1 hb1.cmd_valid = 1'b0;
    first_valid = -1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        cpu_data_out = 8'h5A;
        {cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow} = 3'b110;
      end else if (k == 2) begin
        cpu_data_out = 8'hC3;
        {cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow} = 3'b001;
      end else begin
        cpu_data_out = 8'hEE;
        {cpu_flag_carry, cpu_flag_sign, cpu_flag_overflow} = 3'b111;
      end
      @(negedge clk);
      if (hb1.rsp_valid === 1'b1 && first_valid < 0) first_valid = k;
      check("h1_cpu_data_in", 32'(cpu_data_in1), 32'h58001);
      @(posedge clk);
      #1;
    end
    cpu_data_out = 8'h00;
    @(negedge clk);
    if (hb1.rsp_valid === 1'b1 && first_valid < 0) first_valid = 3;
    check("h1_latency", 32'(first_valid), 32'd3);
    check("h1_result", 32'(hb1.rsp_result), 32'h00005AC3);
    check("h1_flags", 32'({hb1.rsp_carry, hb1.rsp_sign, hb1.rsp_overflow}), 32'b001);
    hb1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("h1_txn_count", 32'(txn1), 32'd1);
    check("h1_rsp_valid_low", 32'(hb1.rsp_valid), 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
